// File: rtl/keypad_encoder.sv
// Debounced 16-button encoder: sync, debounce, rising-press detect, and a small code FIFO
// popped by the game logic with a rd/valid handshake.
module keypad_encoder #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pb,
  input  logic        rd,
  output logic [3:0]  code,
  output logic        valid,
  output logic        full,
  output logic        overflow,
  output logic        held
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]    CntMax  = 4'(DEBOUNCE - 1);
  localparam logic [AW:0]   OccFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   OccOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [15:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0]   cand_q, cand_d, stable_q, stable_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          stable_nz_q, stable_nz_d;
  logic          ev_q, ev_d;
  logic [3:0]    ev_code_q, ev_code_d;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  always_comb begin
    sync1_d     = pb;
    sync2_d     = sync1_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    stable_nz_d = (stable_q != '0);
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    ovf_d       = ovf_q;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      stable_d = cand_q;
    end

    // Only a zero -> non-zero transition of the debounced vector is a press.
    ev_d      = !stable_nz_q && (stable_q != '0);
    ev_code_d = '0;
    for (int i = 0; i < 16; i++) begin
      if (stable_q[i]) ev_code_d = 4'(i);
    end

    pop  = rd && valid;
    push = ev_q && (!full || pop);
    if (ev_q && full && !pop) ovf_d = 1'b1;

    if (push) begin
      mem_d[wptr_q] = ev_code_q;
      wptr_d        = wptr_q + PtrOne;
    end
    if (pop) rptr_d = rptr_q + PtrOne;
    if (push && !pop) occ_d = occ_q + OccOne;
    else if (pop && !push) occ_d = occ_q - OccOne;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      stable_q    <= '0;
      stable_nz_q <= 1'b0;
      ev_q        <= 1'b0;
      ev_code_q   <= '0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      stable_nz_q <= stable_nz_d;
      ev_q        <= ev_d;
      ev_code_q   <= ev_code_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      ovf_q       <= ovf_d;
    end
  end

  assign valid    = (occ_q != '0);
  assign full     = (occ_q == OccFull);
  assign code     = valid ? mem_q[rptr_q] : 4'd0;
  assign held     = (stable_q != '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: run-length/queue reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_keypad_encoder;

  localparam int unsigned DEB = 3;
  localparam int unsigned DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pb  = '0;
  logic        rd  = 1'b0;
  logic [3:0]  code;
  logic        valid, full, overflow, held;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  keypad_encoder #(.DEBOUNCE(DEB), .DEPTH(DEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .pb       (pb),
    .rd       (rd),
    .code     (code),
    .valid    (valid),
    .full     (full),
    .overflow (overflow),
    .held     (held)
  );

  // Reference model: two-sample delay, run-length debounce, queue FIFO.
  logic [15:0] m_s1 = '0, m_s2 = '0, m_runval = '0, m_stable = '0, m_stable_old = '0;
  int          m_run = 1;
  logic        m_ev = 1'b0, m_ovf = 1'b0, m_pop;
  logic [3:0]  m_ev_code = '0;
  logic [3:0]  m_q[$];

  function automatic logic [3:0] hi_idx(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_runval = '0; m_stable = '0; m_stable_old = '0;
      m_run = 1; m_ev = 1'b0; m_ev_code = '0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      m_pop = rd && (m_q.size() != 0);
      if (m_pop) void'(m_q.pop_front());
      if (m_ev) begin
        if (m_q.size() < DEP) m_q.push_back(m_ev_code);
        else m_ovf = 1'b1;
      end
      m_ev         = (m_stable != '0) && (m_stable_old == '0);
      m_ev_code    = hi_idx(m_stable);
      m_stable_old = m_stable;
      if (m_s2 == m_runval) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_runval = m_s2;
        m_run    = 1;
      end
      if (m_run >= DEB + 1) m_stable = m_runval;
      m_s2 = m_s1;
      m_s1 = pb;
    end
  end

  logic [3:0] e_code;
  logic       e_valid, e_full, e_held;

  always @(negedge clk) begin
    if (!rst) begin
      e_valid = (m_q.size() != 0);
      e_code  = e_valid ? m_q[0] : 4'd0;
      e_full  = (m_q.size() == DEP);
      e_held  = (m_stable != '0);
      n_vec++;
      if (code !== e_code || valid !== e_valid || full !== e_full ||
          overflow !== m_ovf || held !== e_held) begin
        n_err++;
        $display("FAIL model t=%0t: got code=%0d valid=%b full=%b ovf=%b held=%b, expected code=%0d valid=%b full=%b ovf=%b held=%b",
                 $time, code, valid, full, overflow, held, e_code, e_valid, e_full, m_ovf, e_held);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_once();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic press_release(input int k);
    pb = '0;
    pb[k] = 1'b1;
    tick(8);
    pb = '0;
    tick(8);
  endtask

  int keys[5] = '{1, 4, 6, 11, 15};

  initial begin
    rst = 1'b1;
    tick(2);
    check("reset code", code, 0);
    check("reset valid", valid, 0);
    check("reset full", full, 0);
    check("reset overflow", overflow, 0);
    check("reset held", held, 0);
    rst = 1'b0;

    // Reset in the middle of debouncing pb[7]
    pb = 16'h0080;
    tick(3);
    rst = 1'b1;
    #1;
    check("midrst valid", valid, 0);
    check("midrst held", held, 0);
    check("midrst code", code, 0);
    tick(1);
    rst = 1'b0;
    tick(7);
    check("midrst latency valid", valid, 0);
    tick(1);
    check("midrst valid", valid, 1);
    check("midrst code", code, 7);
    pop_once();
    check("midrst single entry", valid, 0);
    pb = '0;
    tick(10);

    // Single press of pb[5]
    pb = 16'h0020;
    tick(7);
    check("single pre valid", valid, 0);
    tick(1);
    check("single valid", valid, 1);
    check("single code", code, 5);
    check("single held", held, 1);
    tick(4);
    pop_once();
    check("single popped valid", valid, 0);
    check("single popped code", code, 0);
    pb = '0;
    tick(10);
    check("single released held", held, 0);

    // Glitch of 3 cycles on pb[3]
    pb = 16'h0008;
    tick(3);
    pb = '0;
    tick(10);
    check("glitch valid", valid, 0);
    check("glitch held", held, 0);

    // Multi-key: highest index wins, no re-trigger without release
    pb = 16'h0204;
    tick(8);
    check("multi code", code, 9);
    pop_once();
    pb = 16'h0004;
    tick(10);
    check("multi no new entry", valid, 0);
    check("multi still held", held, 1);
    pb = '0;
    tick(10);
    pb = 16'h0004;
    tick(8);
    check("multi repress code", code, 2);
    pop_once();
    pb = '0;
    tick(10);

    // Overflow with five presses and no pops
    for (int i = 0; i < 5; i++) begin
      press_release(keys[i]);
      if (i == 3) begin
        check("ovf full after 4", full, 1);
        check("ovf clear after 4", overflow, 0);
      end
    end
    check("ovf sticky", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf pop code", code, 32'(keys[i]));
      pop_once();
    end
    check("ovf drained", valid, 0);
    check("ovf still set", overflow, 1);

    // Push and pop on the same edge while full
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) press_release(keys[i]);
    check("simul full before", full, 1);
    pb = 16'h2000;
    tick(7);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    pb = '0;
    check("simul overflow", overflow, 0);
    check("simul full", full, 1);
    for (int i = 0; i < 4; i++) begin
      check("simul pop code", code, (i == 3) ? 32'd13 : 32'(keys[i + 1]));
      pop_once();
    end
    check("simul drained", valid, 0);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
